adc_conv_scheduler: RTL and testbench

Shares the single-slope ADC counter array between two requesters and sequences its `enable` input. It grants one requester at a time, runs a programmed number of back-to-back conversion frames and adds a short flush so the last frame's result reaches the ADC output buffer. It then signals completion and enforces an idle gap before the next grant. It sits between the acquisition clients and the ADC counter, whose `enable` is driven only by this block.

---
 rtl/adc_conv_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_adc_conv_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler
// ------------------
// Shares the single-slope ADC counter array between two requesters. Grants
// one requester at a time, keeps the ADC counter enabled for the programmed
// number of back-to-back conversion frames, then runs a short flush so the
// last frame's result reaches the ADC output buffer. After that it signals
// completion and holds an enable-low gap before the next grant.
//
// Optional build macro:
//   ADC_SEQ_RR_EN  defined   -> round-robin arbitration (on a tie, the
//                               requester that did not win last time wins)
//                  undefined -> fixed priority, req[0] beats req[1]
//
// Parameters:
//   FRAME_CYCLES  enabled cycles per ADC frame (1 load + 7 reset + 255 ramp)
//   RESULT_IDX    in-frame cycle at which the previous frame's result is valid
//   GAP_CYCLES    minimum enable-low cycles between jobs (>= 1)
//
// Ports:
//   clk           single clock, shared with the ADC counter
//   reset         asynchronous, active-high
//   req[1:0]      level request per requester, held until its done pulse
//   frames0/1     frame count per requester, sampled at grant (0 = 256)
//   adc_enable    drives the ADC counter enable
//   grant[1:0]    one-hot owner, 0 when idle or in the gap
//   busy          high from grant through the end of the gap
//   frame_start   pulse on in-frame cycle 0 of every full frame
//   result_valid  pulse when a completed frame's result is on the ADC output
//   result_idx    0-based index of the frame whose result is valid
//   done[1:0]     one-cycle pulse to the owner together with its last result
//
// All outputs are registered.

module adc_conv_scheduler #(
  parameter int unsigned FRAME_CYCLES = 263,
  parameter int unsigned RESULT_IDX   = 2,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [7:0] frames0,
  input  logic [7:0] frames1,
  output logic       adc_enable,
  output logic [1:0] grant,
  output logic       busy,
  output logic       frame_start,
  output logic       result_valid,
  output logic [7:0] result_idx,
  output logic [1:0] done
);

  localparam int unsigned CW = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] C_RES  = CW'(RESULT_IDX);
  localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
  localparam bit            HAS_GAP = (GAP_CYCLES > 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    GAP
  } state_t;

  state_t         state;
  logic [CW-1:0]  c;
  logic [7:0]     fidx;
  logic [8:0]     left;
  logic [GW-1:0]  gcnt;
  logic           owner;

`ifdef ADC_SEQ_RR_EN
  logic           last_win;
`endif

  state_t         nxt_state;
  logic [CW-1:0]  nxt_c;
  logic [7:0]     nxt_fidx;
  logic [8:0]     nxt_left;
  logic [GW-1:0]  nxt_gcnt;
  logic           nxt_owner;

  logic           pick;
  logic [7:0]     pick_frames;
  state_t         after_job;

  logic           n_en;
  logic [1:0]     n_grant;
  logic           n_busy;
  logic           n_fs;
  logic           n_rv;
  logic [1:0]     n_done;
  logic [7:0]     n_ridx;

  // Arbitration winner; only meaningful while some req is high in IDLE.
  always_comb begin
`ifdef ADC_SEQ_RR_EN
    if (req == 2'b11) begin
      pick = ~last_win;
    end else begin
      pick = req[1] & ~req[0];
    end
`else
    pick = ~req[0];
`endif
    pick_frames = pick ? frames1 : frames0;
  end

  // Next-state logic. The gap state holds GAP_CYCLES-1 cycles; together with
  // the IDLE cycle that precedes any new grant this yields GAP_CYCLES
  // enable-low cycles, and busy falls GAP_CYCLES cycles after done.
  always_comb begin
    after_job = HAS_GAP ? GAP : IDLE;
    nxt_state = state;
    nxt_c     = c;
    nxt_fidx  = fidx;
    nxt_left  = left;
    nxt_gcnt  = gcnt;
    nxt_owner = owner;

    unique case (state)
      IDLE: begin
        if (|req) begin
          nxt_state = RUN;
          nxt_owner = pick;
          nxt_c     = '0;
          nxt_fidx  = '0;
          // A count of 0 becomes {1,00000000} = 256.
          nxt_left  = {(pick_frames == 8'd0), pick_frames};
        end
      end

      RUN: begin
        if (!req[owner]) begin
          nxt_state = after_job;
          nxt_gcnt  = '0;
        end else if (c == C_LAST) begin
          nxt_c    = '0;
          nxt_fidx = fidx + 8'd1;
          nxt_left = left - 9'd1;
          if (left == 9'd1) begin
            nxt_state = FLUSH;
          end
        end else begin
          nxt_c = c + CW'(1);
        end
      end

      FLUSH: begin
        if (!req[owner]) begin
          nxt_state = after_job;
          nxt_gcnt  = '0;
        end else if (c == C_RES) begin
          nxt_state = after_job;
          nxt_gcnt  = '0;
        end else begin
          nxt_c = c + CW'(1);
        end
      end

      GAP: begin
        if (gcnt == G_LAST) begin
          nxt_state = IDLE;
        end else begin
          nxt_gcnt = gcnt + GW'(1);
        end
      end

      default: nxt_state = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so that, once registered, they
  // describe the same cycle as the state registers.
  always_comb begin
    n_en    = (nxt_state == RUN) || (nxt_state == FLUSH);
    n_grant = n_en ? (nxt_owner ? 2'b10 : 2'b01) : '0;
    n_busy  = (nxt_state != IDLE);
    n_fs    = (nxt_state == RUN) && (nxt_c == '0);
    n_rv    = ((nxt_state == RUN) && (nxt_c == C_RES) && (nxt_fidx != '0)) ||
              ((nxt_state == FLUSH) && (nxt_c == C_RES));
    n_done  = ((nxt_state == FLUSH) && (nxt_c == C_RES)) ? n_grant : '0;
    n_ridx  = nxt_fidx - 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      c            <= '0;
      fidx         <= '0;
      left         <= '0;
      gcnt         <= '0;
      owner        <= 1'b0;
`ifdef ADC_SEQ_RR_EN
      last_win     <= 1'b1;
`endif
      adc_enable   <= 1'b0;
      grant        <= '0;
      busy         <= 1'b0;
      frame_start  <= 1'b0;
      result_valid <= 1'b0;
      result_idx   <= '0;
      done         <= '0;
    end else begin
      state        <= nxt_state;
      c            <= nxt_c;
      fidx         <= nxt_fidx;
      left         <= nxt_left;
      gcnt         <= nxt_gcnt;
      owner        <= nxt_owner;
`ifdef ADC_SEQ_RR_EN
      if ((state == IDLE) && (|req)) begin
        last_win <= pick;
      end
`endif
      adc_enable   <= n_en;
      grant        <= n_grant;
      busy         <= n_busy;
      frame_start  <= n_fs;
      result_valid <= n_rv;
      if (n_rv) begin
        result_idx <= n_ridx;
      end
      done         <= n_done;
    end
  end

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Self-checking bench for adc_conv_scheduler: a table of jobs plus
// hand-written abort and asynchronous-reset sequences. Expected frame_start
// and result events are queued when a job is launched and popped by a
// monitor as the design produces them.

module tb_adc_conv_scheduler;

  localparam int FC  = 263;
  localparam int RI  = 2;
  localparam int GAP = 4;

`ifdef ADC_SEQ_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [7:0] frames0;
  logic [7:0] frames1;
  logic       adc_enable;
  logic [1:0] grant;
  logic       busy;
  logic       frame_start;
  logic       result_valid;
  logic [7:0] result_idx;
  logic [1:0] done;

  adc_conv_scheduler #(
    .FRAME_CYCLES(FC),
    .RESULT_IDX  (RI),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .frames0     (frames0),
    .frames1     (frames1),
    .adc_enable  (adc_enable),
    .grant       (grant),
    .busy        (busy),
    .frame_start (frame_start),
    .result_valid(result_valid),
    .result_idx  (result_idx),
    .done        (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] idx;
    logic [1:0] dn;
  } res_t;

  typedef struct {
    logic [1:0] req;
    logic [7:0] f0;
    logic [7:0] f1;
    logic       own;
    bit         keep;
  } vec_t;

  res_t exp_res[$];
  int   exp_fs[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   en_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    res_t r;
    int   f;
    forever begin
      @(negedge clk);
      if (adc_enable) en_cnt++;
      if (result_valid) begin
        if (exp_res.size() == 0) begin
          chk("unexpected_result_valid", 1, 0);
        end else begin
          r = exp_res.pop_front();
          chk("result_cycle", cyc, r.cyc);
          chk("result_idx", int'(result_idx), int'(r.idx));
          chk("result_done", int'(done), int'(r.dn));
        end
      end else if (done != 2'b00) begin
        chk("done_without_result", int'(done), 0);
      end
      if (frame_start) begin
        if (exp_fs.size() == 0) begin
          chk("unexpected_frame_start", 1, 0);
        end else begin
          f = exp_fs.pop_front();
          chk("frame_start_cycle", cyc, f);
        end
      end
    end
  endtask

  // Job granted at cycle g to requester own, n frames long.
  task automatic job(input int g, input logic own, input int n, input bit keep);
    int         d;
    int         base;
    logic [1:0] oh;
    res_t       r;
    oh   = own ? 2'b10 : 2'b01;
    base = en_cnt;
    d    = g + n * FC + RI;
    for (int f = 0; f < n; f++) begin
      exp_fs.push_back(g + f * FC);
      r.cyc = g + (f + 1) * FC + RI;
      r.idx = 8'(f);
      r.dn  = (f == n - 1) ? oh : 2'b00;
      exp_res.push_back(r);
    end
    while (cyc < g) @(negedge clk);
    chk("grant_at_start", int'(grant), int'(oh));
    chk("busy_at_start", int'(busy), 1);
    chk("enable_at_start", int'(adc_enable), 1);
    while (cyc < d) @(negedge clk);
    if (!keep) req = 2'b00;
    @(negedge clk);
    chk("enable_after_done", int'(adc_enable), 0);
    chk("grant_after_done", int'(grant), 0);
    chk("busy_in_gap", int'(busy), 1);
    while (cyc < d + GAP - 1) @(negedge clk);
    chk("busy_end_of_gap", int'(busy), 1);
    @(negedge clk);
    chk("busy_after_gap", int'(busy), 0);
    chk("enable_length", en_cnt - base, n * FC + RI + 1);
  endtask

  initial begin
    #(1_500_000 * 10);
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   g;
    int   n;
    logic [7:0] fr;

    vecs[0] = '{req: 2'b01, f0: 8'd1, f1: 8'd5, own: 1'b0, keep: 1'b0};
    vecs[1] = '{req: 2'b10, f0: 8'd9, f1: 8'd3, own: 1'b1, keep: 1'b0};
    vecs[2] = '{req: 2'b11, f0: 8'd1, f1: 8'd1, own: 1'b0, keep: 1'b1};
    vecs[3] = '{req: 2'b11, f0: 8'd1, f1: 8'd1, own: RR,   keep: 1'b1};
    vecs[4] = '{req: 2'b11, f0: 8'd1, f1: 8'd1, own: 1'b0, keep: 1'b0};
    vecs[5] = '{req: 2'b01, f0: 8'd0, f1: 8'd7, own: 1'b0, keep: 1'b0};

    reset   = 1'b1;
    req     = 2'b00;
    frames0 = 8'd0;
    frames1 = 8'd0;
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("reset_adc_enable", int'(adc_enable), 0);
    chk("reset_grant", int'(grant), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_start", int'(frame_start), 0);
    chk("reset_result_valid", int'(result_valid), 0);
    chk("reset_result_idx", int'(result_idx), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      req     = vecs[i].req;
      frames0 = vecs[i].f0;
      frames1 = vecs[i].f1;
      g  = cyc + 1;
      fr = vecs[i].own ? vecs[i].f1 : vecs[i].f0;
      n  = (fr == 8'd0) ? 256 : int'(fr);
      job(g, vecs[i].own, n, vecs[i].keep);
    end

    // Abort: requester 0 drops req during in-frame cycle 100 of a 2-frame job.
    req     = 2'b01;
    frames0 = 8'd2;
    g = cyc + 1;
    exp_fs.push_back(g);
    while (cyc < g + 100) @(negedge clk);
    chk("abort_enable_before_drop", int'(adc_enable), 1);
    req = 2'b00;
    @(negedge clk);
    chk("abort_enable_off", int'(adc_enable), 0);
    chk("abort_grant_off", int'(grant), 0);
    chk("abort_busy_gap", int'(busy), 1);
    while (cyc < g + 100 + GAP - 1) @(negedge clk);
    chk("abort_busy_end_of_gap", int'(busy), 1);
    @(negedge clk);
    chk("abort_busy_low", int'(busy), 0);
    while (cyc < g + 3 * FC) @(negedge clk);
    chk("abort_stays_idle", int'(busy), 0);

    // Asynchronous reset in the middle of a job.
    req     = 2'b10;
    frames1 = 8'd2;
    g = cyc + 1;
    exp_fs.push_back(g);
    while (cyc < g + 50) @(negedge clk);
    chk("pre_reset_enable", int'(adc_enable), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_enable", int'(adc_enable), 0);
    chk("async_reset_grant", int'(grant), 0);
    chk("async_reset_busy", int'(busy), 0);
    req = 2'b00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    req     = 2'b10;
    frames1 = 8'd1;
    g = cyc + 1;
    job(g, 1'b1, 1, 1'b0);

    repeat (10) @(negedge clk);
    chk("leftover_results", exp_res.size(), 0);
    chk("leftover_frame_starts", exp_fs.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
